// File: rtl/gobou_layer_sched_if.sv
// Handshake and per-layer configuration bus between the layer scheduler
// (master) and gobou_ctrl (slave).
interface gobou_layer_sched_if #(
    parameter int LWIDTH        = 10,
    parameter int IMGSIZE       = 12,
    parameter int GOBOU_NETSIZE = 11
) ();
    logic                     req;
    logic                     ack;
    logic [LWIDTH-1:0]        total_in;
    logic [LWIDTH-1:0]        total_out;
    logic [IMGSIZE-1:0]       input_addr;
    logic [IMGSIZE-1:0]       output_addr;
    logic [GOBOU_NETSIZE-1:0] net_addr;

    modport master (
        output req, total_in, total_out, input_addr, output_addr, net_addr,
        input  ack
    );

    modport slave (
        input  req, total_in, total_out, input_addr, output_addr, net_addr,
        output ack
    );
endinterface

// File: rtl/gobou_layer_sched.sv
// gobou_layer_sched: walks a host-written table of FC layer descriptors,
// presenting each layer's geometry/addresses to gobou_ctrl and running one
// req/ack transaction per layer.
// Optional build macro GOBOU_SCHED_PERF_EN adds the perf_cycles run counter.
module gobou_layer_sched #(
    parameter int LWIDTH        = 10,
    parameter int IMGSIZE       = 12,
    parameter int GOBOU_NETSIZE = 11,
    parameter int LAYERLOG      = 3
) (
    input  logic                     clk,
    input  logic                     xrst,
    input  logic                     cfg_we,
    input  logic [LAYERLOG-1:0]      cfg_layer,
    input  logic [LWIDTH-1:0]        cfg_total_in,
    input  logic [LWIDTH-1:0]        cfg_total_out,
    input  logic [IMGSIZE-1:0]       cfg_input_addr,
    input  logic [IMGSIZE-1:0]       cfg_output_addr,
    input  logic [GOBOU_NETSIZE-1:0] cfg_net_addr,
    input  logic [LAYERLOG:0]        num_layers,
    input  logic                     start,
    input  logic                     abort,
    output logic                     busy,
    output logic                     done,
    output logic [LAYERLOG-1:0]      cur_layer,
`ifdef GOBOU_SCHED_PERF_EN
    output logic [31:0]              perf_cycles,
`endif
    gobou_layer_sched_if.master      gob
);

    localparam int DEPTH = 2 ** LAYERLOG;
    localparam logic [LAYERLOG:0] MAX_COUNT = (LAYERLOG + 1)'(DEPTH);

    typedef struct packed {
        logic [LWIDTH-1:0]        total_in;
        logic [LWIDTH-1:0]        total_out;
        logic [IMGSIZE-1:0]       input_addr;
        logic [IMGSIZE-1:0]       output_addr;
        logic [GOBOU_NETSIZE-1:0] net_addr;
    } desc_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_REQ,
        S_GAP,
        S_FIN
    } state_t;

    state_t            state;
    state_t            state_next;
    desc_t             desc_table [DEPTH];
    desc_t             desc_out;
    logic [LAYERLOG:0] idx;
    logic [LAYERLOG:0] idx_inc;
    logic [LAYERLOG:0] count;
    logic [LAYERLOG:0] count_clamped;
    logic              start_ok;

    assign idx_inc       = idx + 1'b1;
    assign count_clamped = (num_layers > MAX_COUNT) ? MAX_COUNT : num_layers;
    // abort outranks start even while idle
    assign start_ok      = (state == S_IDLE) && start && !abort;

    // Status and handshake are pure decodes of the registered state.
    assign busy            = (state != S_IDLE);
    assign done            = (state == S_FIN);
    assign gob.req         = (state == S_REQ);
    assign gob.total_in    = desc_out.total_in;
    assign gob.total_out   = desc_out.total_out;
    assign gob.input_addr  = desc_out.input_addr;
    assign gob.output_addr = desc_out.output_addr;
    assign gob.net_addr    = desc_out.net_addr;

    // State register.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; abort overrides every other transition.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start_ok) begin
                    state_next = (count_clamped == '0) ? S_FIN : S_LOAD;
                end
            end
            S_LOAD: state_next = S_REQ;
            S_REQ: begin
                if (gob.ack) begin
                    state_next = S_GAP;
                end
            end
            S_GAP:  state_next = (idx_inc == count) ? S_FIN : S_LOAD;
            S_FIN:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (abort) begin
            state_next = S_IDLE;
        end
    end

    // Descriptor table: host writes accepted only while idle.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                desc_table[i] <= '0;
            end
        end else if (cfg_we && (state == S_IDLE)) begin
            desc_table[cfg_layer] <= '{
                total_in:    cfg_total_in,
                total_out:   cfg_total_out,
                input_addr:  cfg_input_addr,
                output_addr: cfg_output_addr,
                net_addr:    cfg_net_addr
            };
        end
    end

    // Run bookkeeping and the held per-layer configuration outputs.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            count     <= '0;
            idx       <= '0;
            cur_layer <= '0;
            desc_out  <= '0;
        end else if (start_ok) begin
            count <= count_clamped;
            idx   <= '0;
        end else if (!abort) begin
            case (state)
                S_LOAD: begin
                    desc_out  <= desc_table[idx[LAYERLOG-1:0]];
                    cur_layer <= idx[LAYERLOG-1:0];
                end
                S_GAP:   idx <= idx_inc;
                default: ;
            endcase
        end
    end

`ifdef GOBOU_SCHED_PERF_EN
    // Saturating count of busy cycles, restarted by each accepted start.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            perf_cycles <= '0;
        end else if (start_ok) begin
            perf_cycles <= '0;
        end else if (busy && (perf_cycles != '1)) begin
            perf_cycles <= perf_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_gobou_layer_sched.sv
// Testbench for gobou_layer_sched: directed runs checked every cycle against a
// latency-based transaction model, plus hand-computed literal expectations.
module tb_gobou_layer_sched;

    logic        clk = 1'b0;
    logic        xrst = 1'b0;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_layer = '0;
    logic [9:0]  cfg_total_in = '0;
    logic [9:0]  cfg_total_out = '0;
    logic [11:0] cfg_input_addr = '0;
    logic [11:0] cfg_output_addr = '0;
    logic [10:0] cfg_net_addr = '0;
    logic [3:0]  num_layers = '0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        busy;
    logic        done;
    logic [2:0]  cur_layer;
`ifdef GOBOU_SCHED_PERF_EN
    logic [31:0] perf_cycles;
`endif

    gobou_layer_sched_if #(.LWIDTH(10), .IMGSIZE(12), .GOBOU_NETSIZE(11)) gob ();

    gobou_layer_sched #(
        .LWIDTH(10), .IMGSIZE(12), .GOBOU_NETSIZE(11), .LAYERLOG(3)
    ) dut (
        .clk(clk), .xrst(xrst),
        .cfg_we(cfg_we), .cfg_layer(cfg_layer),
        .cfg_total_in(cfg_total_in), .cfg_total_out(cfg_total_out),
        .cfg_input_addr(cfg_input_addr), .cfg_output_addr(cfg_output_addr),
        .cfg_net_addr(cfg_net_addr),
        .num_layers(num_layers), .start(start), .abort(abort),
        .busy(busy), .done(done), .cur_layer(cur_layer),
`ifdef GOBOU_SCHED_PERF_EN
        .perf_cycles(perf_cycles),
`endif
        .gob(gob)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int req_rises = 0;
    int done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d @%0t", name, got, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    typedef struct {
        int ti; int to; int ia; int oa; int na;
    } mdesc_t;

    mdesc_t      m_table [8];
    mdesc_t      m_cfg;
    bit          m_busy = 0;
    bit          m_req = 0;
    bit          m_done = 0;
    int          m_cur = 0;
    int          m_cnt = 0;
    int          m_next = 0;
    int          t = 0;
    int          req_t = -1;
    int          done_t = -1;
    logic [31:0] m_perf = '0;
    bit          prev_req = 0;

    // Compare current outputs, then advance the model with the inputs that the
    // next rising edge will sample.
    always @(negedge clk) begin
        bit n_busy, n_req, n_done;
        int nt;
        if (xrst) begin
            chk("busy", 32'(busy), 32'(m_busy));
            chk("done", 32'(done), 32'(m_done));
            chk("req", 32'(gob.req), 32'(m_req));
            chk("cur_layer", 32'(cur_layer), m_cur);
            chk("total_in", 32'(gob.total_in), m_cfg.ti);
            chk("total_out", 32'(gob.total_out), m_cfg.to);
            chk("input_addr", 32'(gob.input_addr), m_cfg.ia);
            chk("output_addr", 32'(gob.output_addr), m_cfg.oa);
            chk("net_addr", 32'(gob.net_addr), m_cfg.na);
`ifdef GOBOU_SCHED_PERF_EN
            chk("perf_cycles", perf_cycles, m_perf);
`endif
            if (gob.req === 1'b1 && !prev_req) req_rises++;
            prev_req = (gob.req === 1'b1);
            if (done === 1'b1) done_cnt++;

            nt     = t + 1;
            n_busy = m_busy;
            n_req  = m_req;
            n_done = 0;
            if (m_busy && m_perf != 32'hFFFF_FFFF) m_perf = m_perf + 1;
            if (!m_busy) begin
                if (cfg_we) m_table[cfg_layer] = '{int'(cfg_total_in), int'(cfg_total_out),
                    int'(cfg_input_addr), int'(cfg_output_addr), int'(cfg_net_addr)};
                if (start && !abort) begin
                    m_cnt  = (int'(num_layers) > 8) ? 8 : int'(num_layers);
                    m_next = 0;
                    n_busy = 1;
                    m_perf = '0;
                    if (m_cnt == 0) done_t = nt;
                    else req_t = nt + 1;
                end
            end else if (abort) begin
                n_busy = 0;
                n_req  = 0;
                req_t  = -1;
                done_t = -1;
            end else begin
                if (m_done) n_busy = 0;
                if (m_req && gob.ack) begin
                    n_req = 0;
                    m_next++;
                    if (m_next == m_cnt) done_t = nt + 1;
                    else req_t = nt + 2;
                end
            end
            if (nt == req_t) begin
                n_req = 1;
                m_cur = m_next;
                m_cfg = m_table[m_next];
            end
            if (nt == done_t) n_done = 1;
            m_busy = n_busy;
            m_req  = n_req;
            m_done = n_done;
            t      = nt;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_desc(input int l, input int ti, input int to, input int ia,
                              input int oa, input int na);
        cfg_layer       = 3'(l);
        cfg_total_in    = 10'(ti);
        cfg_total_out   = 10'(to);
        cfg_input_addr  = 12'(ia);
        cfg_output_addr = 12'(oa);
        cfg_net_addr    = 11'(na);
        cfg_we          = 1'b1;
        tick();
        cfg_we          = 1'b0;
    endtask

    task automatic start_run(input int n, output int s);
        num_layers = 4'(n);
        start      = 1'b1;
        s          = cyc;
        tick();
        start      = 1'b0;
    endtask

    task automatic wait_req(output int at);
        int n = 0;
        while (gob.req !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) chk("req_wait_timeout", 32'd0, 32'd1);
        at = cyc;
    endtask

    task automatic wait_done();
        int n = 0;
        while (done !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) chk("done_wait_timeout", 32'd0, 32'd1);
    endtask

    task automatic ack_after(input int n, output int a);
        repeat (n) tick();
        a       = cyc;
        gob.ack = 1'b1;
        tick();
        gob.ack = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int s, r0, r1, a0, a1, rr, dc;
        gob.ack = 1'b0;
        repeat (3) @(posedge clk);
        #1 xrst = 1'b1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req", 32'(gob.req), 32'd0);
        chk("rst_total_in", 32'(gob.total_in), 32'd0);

        // Two-layer run; layer-1 rewrite attempted mid-run must be dropped.
        write_desc(0, 784, 100, 0, 1000, 0);
        write_desc(1, 100, 10, 1000, 2000, 512);
        write_desc(2, 333, 44, 2000, 3000, 1024);
        start_run(2, s);
        wait_req(r0);
        chk("start_to_req", 32'(r0 - s), 32'd2);
        chk("l0_total_in", 32'(gob.total_in), 32'd784);
        chk("l0_output_addr", 32'(gob.output_addr), 32'd1000);
        chk("l0_cur_layer", 32'(cur_layer), 32'd0);
        repeat (5) tick();
        write_desc(1, 100, 55, 1000, 2000, 512);
        repeat (14) tick();
        ack_after(0, a0);
        chk("l0_req_len", 32'(a0 - r0), 32'd20);
        wait_req(r1);
        chk("ack_to_req", 32'(r1 - a0), 32'd3);
        chk("l1_total_out", 32'(gob.total_out), 32'd10);
        chk("l1_net_addr", 32'(gob.net_addr), 32'd512);
        chk("l1_cur_layer", 32'(cur_layer), 32'd1);
        ack_after(20, a1);
        tick();
        chk("last_ack_to_done", 32'(done), 32'd1);
        tick();
        chk("busy_after_done", 32'(busy), 32'd0);
        repeat (3) tick();
        chk("run1_req_windows", 32'(req_rises), 32'd2);
        chk("run1_done_pulses", 32'(done_cnt), 32'd1);

        // Zero-layer run: single FIN cycle, no req.
        start_run(0, s);
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_busy", 32'(busy), 32'd1);
        tick();
        chk("zero_busy_end", 32'(busy), 32'd0);
        chk("zero_done_end", 32'(done), 32'd0);
        chk("zero_no_req", 32'(req_rises), 32'd2);

        // Abort five cycles into layer 1, then rerun from layer 0.
        repeat (2) tick();
        start_run(2, s);
        wait_req(r0);
        ack_after(3, a0);
        wait_req(r1);
        repeat (5) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_req", 32'(gob.req), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_cfg_hold", 32'(gob.total_out), 32'd10);
        repeat (6) tick();
        chk("abort_no_done", 32'(done_cnt), 32'd2);
        start_run(1, s);
        wait_req(r0);
        chk("rerun_cur_layer", 32'(cur_layer), 32'd0);
        chk("rerun_total_in", 32'(gob.total_in), 32'd784);
        gob.ack = 1'b1;                 // ack in the very first REQ cycle
        tick();
        gob.ack = 1'b0;
        tick();
        chk("coincident_ack_done", 32'(done), 32'd1);

        // Spurious acks and a second start while running.
        repeat (2) tick();
        gob.ack = 1'b1;
        tick();
        gob.ack = 1'b0;
        dc = done_cnt;
        rr = req_rises;
        start_run(2, s);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_req(r0);
        ack_after(4, a0);
        gob.ack = 1'b1;                 // held through GAP and LOAD
        tick();
        tick();
        gob.ack = 1'b0;
        wait_req(r1);
        chk("spurious_ack_to_req", 32'(r1 - a0), 32'd3);
        chk("spurious_cur_layer", 32'(cur_layer), 32'd1);
        ack_after(2, a1);
        wait_done();
        tick();
        chk("spurious_done_cnt", 32'(done_cnt - dc), 32'd1);
        chk("spurious_req_cnt", 32'(req_rises - rr), 32'd2);

        // Layer count above table depth clamps to 8.
        rr = req_rises;
        start_run(9, s);
        for (int i = 0; i < 8; i++) begin
            wait_req(r0);
            gob.ack = 1'b1;
            tick();
            gob.ack = 1'b0;
        end
        wait_done();
        tick();
        chk("clamp_req_cnt", 32'(req_rises - rr), 32'd8);
        chk("clamp_busy", 32'(busy), 32'd0);

`ifdef GOBOU_SCHED_PERF_EN
        // One layer, ack 10 cycles after req: 1 LOAD + 11 REQ + GAP + FIN.
        repeat (2) tick();
        start_run(1, s);
        wait_req(r0);
        ack_after(10, a0);
        wait_done();
        tick();
        chk("perf_after_done", perf_cycles, 32'd14);
        repeat (3) tick();
        chk("perf_hold", perf_cycles, 32'd14);
`endif

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout @%0t", $time);
        $fatal(1);
    end

endmodule
